gmii_rx_frame_parser: RTL

//  Front end of the GMII traffic analyzer receive path, fed by the same gmii_d/en/er bus as the analyzer stats logic.

---
 rtl/gmii_rx_frame_parser_pkg.sv | 50 +++++
 rtl/gmii_rx_frame_parser_crc32_d8.sv | 24 ++
 rtl/gmii_rx_frame_parser.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_frame_parser_pkg.sv
// Shared constants, states and descriptor bundle for the GMII receive frame parser.
// Covers wire bytes, CRC constants, tail layout and flag bit positions.
package gmii_rx_frame_parser_pkg;

    localparam logic [7:0]  PRE_BYTE     = 8'h55;
    localparam logic [7:0]  SFD_BYTE     = 8'hD5;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
    localparam logic [31:0] NSEC_PER_SEC = 32'd1_000_000_000;
    localparam logic [31:0] LAT_SAT      = 32'hFFFF_FFFF;

    localparam int MAX_PRE   = 7;
    localparam int TAIL_LEN  = 22;
    localparam int TAIL_BITS = TAIL_LEN * 8;

    localparam int FLG_ER   = 0;
    localparam int FLG_FCS  = 1;
    localparam int FLG_RUNT = 2;
    localparam int FLG_OVER = 3;
    localparam int FLG_PRE  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic [15:0] len;
        logic [4:0]  flags;
        logic [63:0] seq;
        logic [47:0] tx_sec;
        logic [31:0] tx_nsec;
        logic [47:0] rx_sec;
        logic [29:0] rx_nsec;
    } desc_t;

    // The CRC engine shifts LSB-first, so its residue is the mirror of the
    // MSB-first constant.
    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gmii_rx_frame_parser_crc32_d8.sv
// One-octet step of the reflected IEEE 802.3 CRC32.
// Purely combinational; the caller owns the register.
module crc32_d8
    import gmii_rx_frame_parser_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive front end: preamble/SFD strip, FCS check, tail extraction,
// rx timestamping and a two-stage descriptor pipeline with one-way latency.
module gmii_rx_frame_parser
    import gmii_rx_frame_parser_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  gmii_d,
    input  logic        gmii_en,
    input  logic        gmii_er,
    input  logic [47:0] sec,
    input  logic [29:0] nsec,
    output logic        idle_octet,
    output logic        frame_valid,
    output logic [15:0] frame_len,
    output logic [4:0]  frame_flags,
    output logic [63:0] frame_seq,
    output logic [47:0] frame_tx_sec,
    output logic [31:0] frame_tx_nsec,
    output logic [47:0] frame_rx_sec,
    output logic [29:0] frame_rx_nsec,
    output logic [31:0] frame_latency
);

    state_t state, state_n;
    logic [2:0] pre_cnt, pre_cnt_n;
    logic start, sfd, shift, end_data, end_drop;

    logic [15:0]          len;
    logic [31:0]          crc, crc_next;
    logic [TAIL_BITS-1:0] tail;
    logic                 er_seen;
    logic [47:0]          rx_sec_q;
    logic [29:0]          rx_nsec_q;

    desc_t d1, s1;
    logic  s1_valid;
    logic  [31:0] lat;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (gmii_d),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            pre_cnt <= '0;
        end else begin
            state   <= state_n;
            pre_cnt <= pre_cnt_n;
        end
    end

    // A preamble cut short by gmii_en=0 is already at its DROP exit, so the
    // bad-preamble descriptor is launched directly from PREAMBLE.
    always_comb begin
        state_n   = state;
        pre_cnt_n = pre_cnt;
        start     = 1'b0;
        sfd       = 1'b0;
        shift     = 1'b0;
        end_data  = 1'b0;
        end_drop  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (gmii_en) begin
                    start = 1'b1;
                    if (gmii_d == PRE_BYTE) begin
                        state_n   = ST_PREAMBLE;
                        pre_cnt_n = 3'd1;
                    end else if (gmii_d == SFD_BYTE) begin
                        state_n = ST_DATA;
                        sfd     = 1'b1;
                    end else begin
                        state_n = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!gmii_en) begin
                    state_n  = ST_IDLE;
                    end_drop = 1'b1;
                end else if (gmii_d == SFD_BYTE) begin
                    state_n = ST_DATA;
                    sfd     = 1'b1;
                end else if (gmii_d == PRE_BYTE && pre_cnt < 3'(MAX_PRE)) begin
                    pre_cnt_n = pre_cnt + 3'd1;
                end else begin
                    state_n = ST_DROP;
                end
            end
            ST_DATA: begin
                if (gmii_en) begin
                    shift = 1'b1;
                end else begin
                    state_n  = ST_IDLE;
                    end_data = 1'b1;
                end
            end
            ST_DROP: begin
                if (!gmii_en) begin
                    state_n  = ST_IDLE;
                    end_drop = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len       <= '0;
            crc       <= '0;
            tail      <= '0;
            er_seen   <= 1'b0;
            rx_sec_q  <= '0;
            rx_nsec_q <= '0;
        end else begin
            if (start) begin
                er_seen <= gmii_er;
            end else if (gmii_en && gmii_er) begin
                er_seen <= 1'b1;
            end
            if (sfd) begin
                crc       <= CRC_INIT;
                len       <= '0;
                tail      <= '0;
                rx_sec_q  <= sec;
                rx_nsec_q <= nsec;
            end else if (shift) begin
                crc  <= crc_next;
                tail <= {tail[TAIL_BITS-9:0], gmii_d};
                if (len != 16'hFFFF) begin
                    len <= len + 16'd1;
                end
            end
        end
    end

    // Oldest tail byte sits in the top octet of the shift register.
    always_comb begin
        d1 = '0;
        if (end_data) begin
            d1.len             = len;
            d1.flags[FLG_ER]   = er_seen;
            d1.flags[FLG_FCS]  = bit_rev32(crc) != CRC_RESIDUE;
            d1.flags[FLG_RUNT] = len < 16'(MIN_FRAME);
            d1.flags[FLG_OVER] = len > 16'(MAX_FRAME);
            d1.rx_sec          = rx_sec_q;
            d1.rx_nsec         = rx_nsec_q;
            if (len >= 16'(TAIL_LEN)) begin
                d1.seq     = tail[175:112];
                d1.tx_sec  = tail[111:64];
                d1.tx_nsec = tail[63:32];
            end
        end else begin
            d1.flags[FLG_PRE] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= end_data | end_drop;
            if (end_data | end_drop) begin
                s1 <= d1;
            end
        end
    end

    always_comb begin
        logic [47:0] diff;
        logic [31:0] rx32;
        diff = s1.rx_sec - s1.tx_sec;
        rx32 = {2'b00, s1.rx_nsec};
        lat  = LAT_SAT;
        if (s1.len < 16'(TAIL_LEN)) begin
            lat = '0;
        end else if (s1.tx_nsec >= NSEC_PER_SEC) begin
            lat = LAT_SAT;
        end else if (diff == 48'd0 && rx32 >= s1.tx_nsec) begin
            lat = rx32 - s1.tx_nsec;
        end else if (diff == 48'd1) begin
            lat = rx32 + NSEC_PER_SEC - s1.tx_nsec;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_octet    <= 1'b0;
            frame_valid   <= 1'b0;
            frame_len     <= '0;
            frame_flags   <= '0;
            frame_seq     <= '0;
            frame_tx_sec  <= '0;
            frame_tx_nsec <= '0;
            frame_rx_sec  <= '0;
            frame_rx_nsec <= '0;
            frame_latency <= '0;
        end else begin
            idle_octet  <= ~gmii_en;
            frame_valid <= s1_valid;
            if (s1_valid) begin
                frame_len     <= s1.len;
                frame_flags   <= s1.flags;
                frame_seq     <= s1.seq;
                frame_tx_sec  <= s1.tx_sec;
                frame_tx_nsec <= s1.tx_nsec;
                frame_rx_sec  <= s1.rx_sec;
                frame_rx_nsec <= s1.rx_nsec;
                frame_latency <= lat;
            end
        end
    end

endmodule
